// File: rtl/brs_pipe_adder.sv
// Pipelined tile adder: add/sub/accumulate/load with optional saturation,
// feeding a 2-entry result buffer over valid/ready handshakes.
module brs_pipe_adder #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [1:0]           in_mode,
    input  logic                 in_sat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_ovf,
    output logic                 out_zero
);

    localparam int AW1 = ACC_WIDTH + 1;

    if (ACC_WIDTH < WIDTH + 1) begin : g_bad_width
        $error("brs_pipe_adder: ACC_WIDTH must be at least WIDTH+1");
    end

    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_SUB  = 2'd1,
        MODE_ACC  = 2'd2,
        MODE_LOAD = 2'd3
    } mode_e;

    typedef struct packed {
        logic [ACC_WIDTH-1:0] sum;
        logic                 ovf;
        logic                 zero;
    } entry_t;

    mode_e                mode;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_nxt;
    logic                 acc_wr;

    logic [WIDTH:0]       add_r;
    logic [WIDTH:0]       sub_r;
    logic [ACC_WIDTH:0]   acc_t;

    logic [ACC_WIDTH-1:0] res_sum;
    logic                 res_ovf;
    entry_t               new_e;

    entry_t               head;
    logic                 head_vld;
    entry_t               tail;
    logic                 tail_vld;

    logic                 push;
    logic                 pop;

    assign mode = mode_e'(in_mode);

    // One spare carry/borrow bit on every datapath.
    assign add_r = {1'b0, in_a} + {1'b0, in_b};
    assign sub_r = {1'b0, in_a} - {1'b0, in_b};
    assign acc_t = {1'b0, acc} + AW1'(in_a) + AW1'(in_b);

    always_comb begin
        res_sum = '0;
        res_ovf = 1'b0;
        acc_nxt = acc;
        acc_wr  = 1'b0;
        unique case (1'b1)
            (mode == MODE_ADD): begin
                res_ovf = add_r[WIDTH];
                if (in_sat && res_ovf)
                    res_sum = ACC_WIDTH'({WIDTH{1'b1}});
                else
                    res_sum = ACC_WIDTH'(add_r[WIDTH-1:0]);
            end
            (mode == MODE_SUB): begin
                res_ovf = sub_r[WIDTH];
                if (in_sat && res_ovf)
                    res_sum = '0;
                else
                    res_sum = ACC_WIDTH'(sub_r[WIDTH-1:0]);
            end
            (mode == MODE_ACC): begin
                res_ovf = acc_t[ACC_WIDTH];
                acc_wr  = 1'b1;
                if (in_sat && res_ovf)
                    acc_nxt = '1;
                else
                    acc_nxt = acc_t[ACC_WIDTH-1:0];
                res_sum = acc_nxt;
            end
            (mode == MODE_LOAD): begin
                acc_wr  = 1'b1;
                acc_nxt = ACC_WIDTH'(add_r);
                res_sum = acc_nxt;
            end
            default: begin
                res_sum = '0;
            end
        endcase
    end

    assign new_e.sum  = res_sum;
    assign new_e.ovf  = res_ovf;
    assign new_e.zero = (res_sum == '0);

    // Tail only fills while head is occupied, so a full buffer
    // is exactly tail_vld; in_ready depends on registered state only.
    assign in_ready = !tail_vld;
    assign push     = in_valid && in_ready;
    assign pop      = head_vld && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (push && acc_wr) begin
            acc <= acc_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            head_vld <= 1'b0;
            tail     <= '0;
            tail_vld <= 1'b0;
        end else begin
            if (tail_vld) begin
                if (pop) begin
                    head     <= tail;
                    tail_vld <= 1'b0;
                end
            end else if (head_vld) begin
                if (push && pop) begin
                    head <= new_e;
                end else if (push) begin
                    tail     <= new_e;
                    tail_vld <= 1'b1;
                end else if (pop) begin
                    head_vld <= 1'b0;
                end
            end else if (push) begin
                head     <= new_e;
                head_vld <= 1'b1;
            end
        end
    end

    // Head register doubles as the output stage, so values hold
    // after the last pop until a new result arrives.
    assign out_valid = head_vld;
    assign out_sum   = head.sum;
    assign out_ovf   = head.ovf;
    assign out_zero  = head.zero;

endmodule

// File: doc/brs_pipe_adder.md
Name: brs_pipe_adder

Overview:
Parametrised, pipelined successor to the combinational tile adder. Accepts operand pairs over a valid/ready handshake and supports add, subtract, accumulate and load modes, with optional saturation. Results pass through a 2-entry output buffer with overflow and zero flags. It sits between the tile pin mux and downstream logic, and can be instantiated per channel.

Parameters:
WIDTH, 8, operand width in bits.
ACC_WIDTH, 16, accumulator and result width in bits; must be >= WIDTH+1 (elaboration error otherwise).

Ports:
clk  input  1  clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand pair present.
in_ready  output  1  block can accept; in_ready = (buffer count < 2); no combinational path from out_ready.
in_a  input  WIDTH  operand A, unsigned.
in_b  input  WIDTH  operand B, unsigned.
in_mode  input  2  00 ADD, 01 SUB, 10 ACC, 11 LOAD.
in_sat  input  1  1 = saturate on overflow, 0 = wrap.
out_valid  output  1  buffer head holds a result.
out_ready  input  1  consumer takes head.
out_sum  output  ACC_WIDTH  result.
out_ovf  output  1  overflow, carry or borrow occurred.
out_zero  output  1  out_sum == 0.

Behaviour:
- Reset (asynchronous assert, clocked release): accumulator 0, buffer count 0; out_valid 0, out_sum 0, out_ovf 0, out_zero 0; in_ready 1 on the first cycle after release.
- Accept occurs on a cycle with in_valid & in_ready. Operands and mode are sampled on that edge. The result enters the buffer on the same edge.
- Latency: out_valid rises the cycle after the first accept into an empty buffer.
- ADD: r = a + b at WIDTH+1 bits. ovf = r[WIDTH]. Wrap: out_sum = r[WIDTH-1:0], zero-extended. Sat with ovf: out_sum = 2^WIDTH-1.
- SUB: r = a - b. ovf = (a < b). Wrap: WIDTH-bit two's-complement result, zero-extended. Sat with ovf: out_sum = 0.
- ACC: t = acc + a + b at ACC_WIDTH+1 bits. ovf = t[ACC_WIDTH]. Wrap: acc <= t[ACC_WIDTH-1:0]. Sat with ovf: acc <= all ones. out_sum = new acc.
- LOAD: acc <= a + b, zero-extended. ovf = 0. out_sum = new acc.
- The accumulator changes only on an accepted ACC or LOAD. ADD and SUB never touch it.
- out_zero is computed on the final (post-saturation) out_sum.
- Buffer: 2-entry FIFO, order preserved.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop when count is 1: count stays 1, and the head advances to the new entry.
  - Push is impossible at count 2 because in_ready is 0.
  - Pop at count 0 is ignored.
- While out_valid & !out_ready, out_sum, out_ovf and out_zero are held stable.
- When out_valid is 0, the outputs hold their last value. The bench checks them only when out_valid is 1.
- Reset mid-operation: buffered results and the accumulator are discarded, and out_valid drops asynchronously with rst.
- in_valid must stay asserted with stable data until accepted. Behaviour on violation is undefined and is not checked.

Test Plan:
1. WIDTH=8. ADD a=200 b=100 sat=0 -> out_sum 0x002C, ovf 1. Same with sat=1 -> 0x00FF, ovf 1. ADD 3+4 -> 0x0007, ovf 0, zero 0. out_valid rises exactly 1 cycle after accept.
2. SUB a=5 b=7 sat=0 -> 0x00FE, ovf 1. sat=1 -> 0x0000, ovf 1, zero 1. SUB 9-9 -> 0x0000, ovf 0, zero 1.
3. LOAD 255+255 -> out_sum 0x01FE. Then 128 × ACC 255+255 with sat=0: the 128th result is 0x00FE with ovf 1, and all earlier results have ovf 0. Repeat with sat=1: the 128th result is 0xFFFF with ovf 1, and a following ACC 0+0 gives 0xFFFF with ovf 0.
4. out_ready=0, offer three ADDs (1+1, 2+2, 3+3) back-to-back -> two accepted, in_ready 0 from the cycle after the second accept. Then out_ready=1 -> outputs 2, 4, 6 in order, and the third is accepted once in_ready rises. out_sum is stable during the stall.
5. Continuous in_valid and out_ready with alternating ADD/SUB -> one result per cycle, count stays at 1 and never reaches 2.
6. LOAD 10+10, then an ACC held in the buffer, then assert rst for 1 cycle -> out_valid 0 immediately. After release, ACC 1+1 -> 0x0002, proving the accumulator was cleared.
